// File: rtl/trigger_deadlock_reporter.sv
// Qualifies persistent HLS deadlock-monitor block flags as a deadlock.
// It latches a diagnostic snapshot and interrupts until software acknowledges.
module trigger_deadlock_reporter #(
  parameter int unsigned NUM_MON   = 1,
  parameter int unsigned NUM_AXIS  = 7,
  parameter int unsigned THRESH_W  = 16,
  parameter int unsigned MON_IDX_W = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [THRESH_W-1:0]  threshold,
  input  logic [NUM_MON-1:0]   mon_block,
  input  logic [NUM_AXIS-1:0]  axis_block_sigs,
  input  logic                 ack,
  output logic                 deadlock_irq,
  output logic                 deadlock_valid,
  output logic [MON_IDX_W-1:0] culprit_mon,
  output logic [NUM_AXIS-1:0]  axis_snapshot,
  output logic [THRESH_W-1:0]  block_cycles,
  output logic [7:0]           event_count
);

  typedef enum logic [1:0] {StIdle, StArmed, StCounting, StDetected} state_e;

  state_e                state_q, state_d;
  logic                  irq_q, irq_d;
  logic [MON_IDX_W-1:0]  culprit_q, culprit_d;
  logic [NUM_AXIS-1:0]   snap_q, snap_d;
  logic [THRESH_W-1:0]   bc_q, bc_d;
  logic [7:0]            evt_q, evt_d;

  logic                  any_blk;
  logic [THRESH_W-1:0]   thr_eff;
  logic [THRESH_W:0]     bc_plus_one;
  logic                  reached;
  logic [THRESH_W-1:0]   bc_inc;
  logic [MON_IDX_W-1:0]  low_idx;
  logic                  detect;

  assign any_blk     = |mon_block;
  assign thr_eff     = (threshold == '0) ? {{(THRESH_W-1){1'b0}}, 1'b1} : threshold;
  // One bit wider so the compare cannot wrap when block_cycles is all-ones.
  assign bc_plus_one = {1'b0, bc_q} + {{THRESH_W{1'b0}}, 1'b1};
  assign reached     = bc_plus_one >= {1'b0, thr_eff};
  assign bc_inc      = (&bc_q) ? bc_q : bc_plus_one[THRESH_W-1:0];

  // Descending scan so the lowest set index is written last.
  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
      if (mon_block[i]) low_idx = MON_IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_d     = 1'b0;
    culprit_d = culprit_q;
    snap_d    = snap_q;
    bc_d      = bc_q;
    evt_d     = evt_q;
    detect    = 1'b0;

    unique case (state_q)
      StIdle: begin
        bc_d = '0;
        if (enable) state_d = StArmed;
      end
      StArmed: begin
        bc_d = '0;
        if (any_blk) begin
          if (thr_eff == {{(THRESH_W-1){1'b0}}, 1'b1}) begin
            detect = 1'b1;
          end else begin
            state_d = StCounting;
            bc_d    = {{(THRESH_W-1){1'b0}}, 1'b1};
          end
        end
      end
      StCounting: begin
        if (!any_blk) begin
          state_d = StArmed;
          bc_d    = '0;
        end else if (reached) begin
          detect = 1'b1;
        end else begin
          bc_d = bc_inc;
        end
      end
      StDetected: begin
        if (ack) begin
          state_d = StArmed;
          bc_d    = '0;
        end else if (any_blk) begin
          bc_d = bc_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    if (detect) begin
      state_d   = StDetected;
      irq_d     = 1'b1;
      culprit_d = low_idx;
      snap_d    = axis_block_sigs;
      bc_d      = bc_inc;
      if (evt_q != 8'hFF) evt_d = evt_q + 8'd1;
    end

    // Disable overrides detection and ack; diagnostics are kept for software.
    if (!enable) begin
      state_d = StIdle;
      irq_d   = 1'b0;
      bc_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      irq_q     <= 1'b0;
      culprit_q <= '0;
      snap_q    <= '0;
      bc_q      <= '0;
      evt_q     <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      culprit_q <= culprit_d;
      snap_q    <= snap_d;
      bc_q      <= bc_d;
      evt_q     <= evt_d;
    end
  end

  assign deadlock_irq   = irq_q;
  assign deadlock_valid = (state_q == StDetected);
  assign culprit_mon    = culprit_q;
  assign axis_snapshot  = snap_q;
  assign block_cycles   = bc_q;
  assign event_count    = evt_q;

endmodule

// File: doc/trigger_deadlock_reporter.md
Name: trigger_deadlock_reporter

Overview:
- Consumer side of the HLS deadlock-monitor interface in the trigger pipeline.
- Takes the registered `block` outputs of one or more per-instance deadlock monitors, plus the raw AXIS channel block vector.
- Qualifies a block as a deadlock only when it persists for a programmable number of consecutive cycles. Then it latches a diagnostic snapshot, raises an interrupt pulse and a sticky valid flag, and holds them until software acknowledges.
- Sits between the monitors and the AXI-Lite status/IRQ logic.

Parameters:
- NUM_MON, 1, number of monitor `block` inputs.
- NUM_AXIS, 7, width of the AXIS block-signal vector snapshotted at detection.
- THRESH_W, 16, width of the persistence threshold and of the block-cycle counter.
- MON_IDX_W, 1, width of the culprit index; must satisfy 2^MON_IDX_W >= NUM_MON.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, detection enable; low forces IDLE.
- threshold, input, THRESH_W, consecutive block cycles required to declare a deadlock; 0 is treated as 1.
- mon_block, input, NUM_MON, per-monitor block flags.
- axis_block_sigs, input, NUM_AXIS, raw AXIS channel block signals.
- ack, input, 1, software acknowledge; single-cycle pulse or level.
- deadlock_irq, output, 1, one-cycle pulse on detection.
- deadlock_valid, output, 1, sticky flag, high in DETECTED.
- culprit_mon, output, MON_IDX_W, lowest-index mon_block bit set in the detection cycle.
- axis_snapshot, output, NUM_AXIS, axis_block_sigs captured in the detection cycle.
- block_cycles, output, THRESH_W, current consecutive-block count; saturates at all-ones.
- event_count, output, 8, number of detections since reset; saturates at 255.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- Reset: state=IDLE. All outputs are 0: deadlock_irq, deadlock_valid, culprit_mon, axis_snapshot, block_cycles, event_count.
- Definitions: any_blk = OR of mon_block. thr_eff = (threshold==0) ? 1 : threshold.
- IDLE:
  - block_cycles held at 0.
  - enable=1 -> ARMED on the next edge.
- ARMED:
  - any_blk=0: stay; block_cycles=0.
  - any_blk=1 and thr_eff==1: detect this cycle (see detection).
  - any_blk=1 and thr_eff>1: -> COUNTING; block_cycles<=1.
- COUNTING:
  - any_blk=0: -> ARMED; block_cycles<=0. Any gap restarts the count.
  - any_blk=1 and block_cycles+1 >= thr_eff: detect.
  - Otherwise: block_cycles<=block_cycles+1, saturating at 2^THRESH_W-1.
- Detection, registered on the edge ending the qualifying cycle:
  - state<=DETECTED; deadlock_irq<=1 for exactly one cycle.
  - culprit_mon and axis_snapshot capture that cycle's inputs.
  - event_count increments unless already 255.
  - block_cycles<=min(block_cycles+1, max).
- Latency: deadlock_irq/deadlock_valid rise thr_eff cycles after the first sampled any_blk=1.
- DETECTED:
  - deadlock_valid=1; snapshot and culprit frozen.
  - block_cycles keeps counting while any_blk=1 and holds (not cleared) when any_blk=0.
  - ack=1: -> ARMED next edge; deadlock_valid<=0, block_cycles<=0. Re-detection requires a fresh thr_eff consecutive cycles.
- ack outside DETECTED is ignored.
- enable=0 in any state -> IDLE next edge, with priority over ack and detection:
  - deadlock_valid<=0, block_cycles<=0, no irq.
  - culprit_mon, axis_snapshot and event_count are retained.
- threshold is sampled every cycle. Lowering it below the current block_cycles while COUNTING with any_blk=1 detects on that cycle.
- Reset mid-operation (any state) returns to the reset values on the next edge. event_count is cleared.

Test Plan:
- Reset then enable=1, threshold=4, mon_block=1 held -> deadlock_irq pulses once on the 4th edge after block asserts. deadlock_valid=1, event_count=1, axis_snapshot equals the applied vector (e.g. 7'h12).
- threshold=4, mon_block pattern 1,1,1,0,1,1,1,1 -> no detection on the first burst. Detection on the 4th cycle of the second burst; block_cycles reaches 0 at the gap.
- NUM_MON=2, mon_block=2'b10 then 2'b11 at detection, threshold=3 -> culprit_mon=0. With only 2'b10 held -> culprit_mon=1.
- In DETECTED with block held, pulse ack -> deadlock_valid=0 next cycle. Re-detection after 4 more cycles; event_count=2, a second single-cycle irq.
- threshold=0, single-cycle mon_block pulse -> immediate detection after 1 cycle. Repeat 256 detections -> event_count saturates at 255.
- During COUNTING (block_cycles=2), drop enable -> IDLE, no irq, block_cycles=0. Asserting reset in DETECTED -> all outputs 0 next cycle.
